// File: rtl/fpu_pkg.sv
// fpu_pkg: shared constants and types for the FP adder back end.
// Rounding-mode encodings, special-value constants and the stage-1 payload.
package fpu_pkg;

  localparam int FRAC_W = 23;
  localparam int CAL_W  = 28;
  localparam int NORM_W = 27;

  localparam logic [7:0]  EXP_MAX = 8'hFF;
  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [31:0] INF     = 32'h7F80_0000;
  localparam logic [31:0] MAXF    = 32'h7F7F_FFFF;

  typedef enum logic [1:0] {
    RM_RNE = 2'b00,
    RM_RDN = 2'b01,
    RM_RUP = 2'b10,
    RM_RTZ = 2'b11
  } rm_e;

  // Normalized fraction plus everything stage 2 needs to round and pack.
  // exp is 9 bits so a carry out of 254 or 255 is still visible as overflow.
  typedef struct packed {
    logic [NORM_W-1:0] f;
    logic [8:0]        exp;
    logic              sign;
    rm_e               rm;
    logic              nan;
    logic              inf;
    logic [FRAC_W-1:0] nan_frac;
  } norm_t;

endpackage

// File: rtl/fadd_lzc.sv
// fadd_lzc: 27-bit leading-zero count, purely combinational.
// An all-zero input reports 27.
module fadd_lzc (
  input  logic [26:0] frac_i,
  output logic [4:0]  count_o
);

  // Scan from LSB upward so the highest set bit is the last one to win.
  always_comb begin
    count_o = 5'd27;
    for (int i = 0; i < 27; i++) begin
      if (frac_i[i]) count_o = 5'(26 - i);
    end
  end

endmodule

// File: rtl/fadd_norm_round.sv
// fadd_norm_round: normalize, round and pack stage of the pipelined FP adder.
// Stage 1 registers the normalized fraction, stage 2 registers the packed
// result. Optional macro FADD_FLAGS_EN adds registered {ovf, unf, inexact};
// without it flags is tied to zero and no flag logic exists.
module fadd_norm_round
  import fpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CAL_W-1:0]  cal_frac,
  input  logic [7:0]        temp_exp,
  input  logic              sign,
  input  logic              op_sub,
  input  logic              s_is_nan,
  input  logic              s_is_inf,
  input  logic [FRAC_W-1:0] inf_nan_frac,
  input  logic [1:0]        rm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       result,
  output logic [2:0]        flags
);

  logic        s1_v_q, s2_v_q;
  logic        s1_en, s2_en;
  norm_t       s1_d, s1_q;
  logic [31:0] result_d, result_q;
  logic [4:0]  lzc;
  logic [4:0]  sh;

  logic [23:0] m;
  logic        x, inc, ovf;
  logic [24:0] sum;
  logic [8:0]  e_r;
  logic [22:0] frac_r;

  fadd_lzc u_lzc (
    .frac_i  (cal_frac[NORM_W-1:0]),
    .count_o (lzc)
  );

  assign in_ready  = ~s1_v_q | ~s2_v_q | out_ready;
  assign s1_en     = in_valid & in_ready;
  assign s2_en     = s1_v_q & (~s2_v_q | out_ready);
  assign out_valid = s2_v_q;
  assign result    = result_q;

  // Stage 1: normalize so the leading one lands on bit 26 where the exponent allows.
  always_comb begin
    s1_d          = '0;
    s1_d.sign     = sign;
    s1_d.rm       = rm_e'(rm);
    s1_d.nan      = s_is_nan;
    s1_d.inf      = s_is_inf;
    s1_d.nan_frac = inf_nan_frac;
    sh            = '0;
    if (cal_frac == '0) begin
      // Exact cancellation: zero is negative only when rounding toward -inf.
      if (!s_is_nan && !s_is_inf && op_sub) s1_d.sign = (rm_e'(rm) == RM_RDN);
    end else if (cal_frac[CAL_W-1]) begin
      s1_d.f   = {cal_frac[27:2], cal_frac[1] | cal_frac[0]};
      s1_d.exp = {1'b0, temp_exp} + 9'd1;
    end else begin
      if (temp_exp == 8'd0) begin
        sh       = '0;
        s1_d.exp = '0;
      end else if (temp_exp > {3'b000, lzc}) begin
        sh       = lzc;
        s1_d.exp = {1'b0, temp_exp} - {4'b0000, lzc};
      end else begin
        // Shift stops at the denormal boundary; temp_exp <= 27 here.
        sh       = temp_exp[4:0] - 5'd1;
        s1_d.exp = '0;
      end
      s1_d.f = cal_frac[NORM_W-1:0] << sh;
      if (s1_d.exp == 9'd0 && s1_d.f[26]) s1_d.exp = 9'd1;
    end
  end

  // Stage 2: round per mode, fix up mantissa carry, saturate and pack.
  always_comb begin
    m   = s1_q.f[26:3];
    x   = |s1_q.f[2:0];
    inc = 1'b0;
    case (s1_q.rm)
      RM_RNE:  inc = s1_q.f[2] & (s1_q.f[1] | s1_q.f[0] | m[0]);
      RM_RDN:  inc = s1_q.sign & x;
      RM_RUP:  inc = ~s1_q.sign & x;
      default: inc = 1'b0;
    endcase
    sum    = {1'b0, m} + {24'd0, inc};
    e_r    = s1_q.exp;
    frac_r = sum[22:0];
    if (sum[24]) begin
      e_r    = s1_q.exp + 9'd1;
      frac_r = sum[23:1];
    end else if (s1_q.exp == 9'd0 && sum[23]) begin
      e_r = 9'd1;
    end
    ovf      = (e_r >= 9'd255);
    result_d = {s1_q.sign, e_r[7:0], frac_r};
    if (ovf) begin
      case (s1_q.rm)
        RM_RNE:  result_d = {s1_q.sign, INF[30:0]};
        RM_RUP:  result_d = s1_q.sign ? {1'b1, MAXF[30:0]} : INF;
        RM_RDN:  result_d = s1_q.sign ? {1'b1, INF[30:0]} : MAXF;
        default: result_d = {s1_q.sign, MAXF[30:0]};
      endcase
    end
    if (s1_q.nan)      result_d = {s1_q.sign, EXP_MAX, s1_q.nan_frac};
    else if (s1_q.inf) result_d = {s1_q.sign, EXP_MAX, 23'd0};
  end

  // Pipeline occupancy: a stage fills on accept and empties when drained.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v_q <= 1'b0;
      s2_v_q <= 1'b0;
    end else begin
      if (s1_en)      s1_v_q <= 1'b1;
      else if (s2_en) s1_v_q <= 1'b0;
      if (s2_en)          s2_v_q <= 1'b1;
      else if (out_ready) s2_v_q <= 1'b0;
    end
  end

  // Stage data registers only load when their stage advances.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q     <= '0;
      result_q <= '0;
    end else begin
      if (s1_en) s1_q     <= s1_d;
      if (s2_en) result_q <= result_d;
    end
  end

`ifdef FADD_FLAGS_EN
  logic [2:0] flags_d, flags_q;

  // Exception flags; specials report nothing.
  always_comb begin
    flags_d = '0;
    if (!s1_q.nan && !s1_q.inf)
      flags_d = {ovf, (e_r == 9'd0) & (x | ovf), x | ovf};
  end

  // Flags travel with the result register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        flags_q <= '0;
    else if (s2_en) flags_q <= flags_d;
  end

  assign flags = flags_q;
`else
  assign flags = 3'b000;
`endif

endmodule

// File: tb/tb_fadd_norm_round.sv
// tb_fadd_norm_round: directed and randomized checks of the normalize/round
// back end against an arithmetic reference model.
module tb_fadd_norm_round;

  typedef struct {
    logic [27:0] cf;
    logic [7:0]  te;
    logic        sg;
    logic        os;
    logic        nan;
    logic        inf;
    logic [22:0] pl;
    logic [1:0]  r;
  } vec_t;

`ifdef FADD_FLAGS_EN
  localparam logic [2:0] FL_MASK = 3'b111;
`else
  localparam logic [2:0] FL_MASK = 3'b000;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [27:0] cal_frac = '0;
  logic [7:0]  temp_exp = '0;
  logic        sign = 1'b0;
  logic        op_sub = 1'b0;
  logic        s_is_nan = 1'b0;
  logic        s_is_inf = 1'b0;
  logic [22:0] inf_nan_frac = '0;
  logic [1:0]  rm = 2'b00;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic [2:0]  flags;

  int checks = 0;
  int errors = 0;
  logic [34:0] exp_q[$];

  always #5 clk = ~clk;

  fadd_norm_round dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .cal_frac     (cal_frac),
    .temp_exp     (temp_exp),
    .sign         (sign),
    .op_sub       (op_sub),
    .s_is_nan     (s_is_nan),
    .s_is_inf     (s_is_inf),
    .inf_nan_frac (inf_nan_frac),
    .rm           (rm),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .result       (result),
    .flags        (flags)
  );

  // Reference: value-level normalize and round, returns {ovf, unf, inexact, result}.
  function automatic logic [34:0] ref_model(input vec_t v);
    int     p, sh, e, ee;
    longint f, m, rem, sum;
    bit     up, x, ovf, unf, inx;
    logic   zs;
    logic [31:0] res;
    if (v.nan) return {3'b000, v.sg, 8'hFF, v.pl};
    if (v.inf) return {3'b000, v.sg, 8'hFF, 23'd0};
    if (v.cf == 28'd0) begin
      zs = v.os ? (v.r == 2'b01) : v.sg;
      return {3'b000, zs, 31'd0};
    end
    p = 0;
    for (int i = 0; i < 28; i++) if (v.cf[i]) p = i;
    if (p == 27) begin
      f = longint'(v.cf) >> 1;
      if (v.cf[0]) f = f | 1;
      e = int'(v.te) + 1;
    end else begin
      ee = (v.te == 8'd0) ? 1 : int'(v.te);
      sh = (v.te == 8'd0) ? 0 : (((26 - p) < (ee - 1)) ? (26 - p) : (ee - 1));
      f  = longint'(v.cf) << sh;
      e  = ee - sh;
      if (f < (longint'(1) << 26)) e = 0;
    end
    m   = f >> 3;
    rem = f % 8;
    x   = (rem != 0);
    case (v.r)
      2'b00:   up = (rem > 4) || (rem == 4 && (m % 2 == 1));
      2'b01:   up = v.sg && x;
      2'b10:   up = !v.sg && x;
      default: up = 1'b0;
    endcase
    sum = m + (up ? 1 : 0);
    if (sum == (longint'(1) << 24)) begin
      sum = longint'(1) << 23;
      e   = e + 1;
    end
    if (e == 0 && sum >= (longint'(1) << 23)) e = 1;
    ovf = (e >= 255);
    inx = x || ovf;
    unf = (e == 0) && inx;
    if (ovf) begin
      case (v.r)
        2'b00:   res = {v.sg, 31'h7F800000};
        2'b01:   res = v.sg ? 32'hFF800000 : 32'h7F7FFFFF;
        2'b10:   res = v.sg ? 32'hFF7FFFFF : 32'h7F800000;
        default: res = {v.sg, 31'h7F7FFFFF};
      endcase
    end else begin
      res = {v.sg, 8'(e), 23'(sum)};
    end
    return {ovf, unf, inx, res};
  endfunction

  function automatic vec_t mkv(input logic [27:0] cf, input logic [7:0] te,
                               input logic sg, input logic os, input logic [1:0] r,
                               input logic nan, input logic inf, input logic [22:0] pl);
    vec_t v;
    v.cf = cf; v.te = te; v.sg = sg; v.os = os; v.r = r;
    v.nan = nan; v.inf = inf; v.pl = pl;
    return v;
  endfunction

  function automatic vec_t gen_vec();
    vec_t v;
    int   k;
    k      = $urandom_range(0, 9);
    v.sg   = 1'($urandom());
    v.os   = 1'($urandom());
    v.r    = 2'($urandom());
    v.pl   = 23'($urandom());
    v.nan  = 1'b0;
    v.inf  = 1'b0;
    if (k <= 2) begin
      v.cf = {1'b1, 27'($urandom())};
      v.te = 8'($urandom_range(1, 254));
    end else if (k <= 5) begin
      v.cf = {2'b01, 26'($urandom())};
      v.te = 8'($urandom_range(0, 254));
    end else if (k <= 7) begin
      v.cf = {2'b00, 26'($urandom())} >> $urandom_range(0, 25);
      v.te = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 30)) : 8'($urandom_range(1, 254));
    end else if (k == 8) begin
      v.cf = '0;
      v.te = 8'($urandom_range(0, 254));
    end else begin
      v.cf  = {2'b01, 26'($urandom())};
      v.te  = 8'($urandom_range(1, 254));
      v.nan = 1'($urandom());
      v.inf = ~v.nan;
    end
    return v;
  endfunction

  task automatic apply(input vec_t v);
    cal_frac     = v.cf;
    temp_exp     = v.te;
    sign         = v.sg;
    op_sub       = v.os;
    s_is_nan     = v.nan;
    s_is_inf     = v.inf;
    inf_nan_frac = v.pl;
    rm           = v.r;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++;
    if (result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h want 00000000", result); end
    checks++;
    if (flags !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", flags); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    vec_t        dv[17];
    logic [31:0] dres[17];
    logic [2:0]  dfl[17];
    int          lat;
    dv[0]  = mkv(28'h8000000, 8'h7F, 0, 0, 2'b00, 0, 0, 0); dres[0]  = 32'h40000000; dfl[0]  = 3'b000;
    dv[1]  = mkv(28'h0000008, 8'h80, 0, 1, 2'b00, 0, 0, 0); dres[1]  = 32'h34800000; dfl[1]  = 3'b000;
    dv[2]  = mkv(28'h4000004, 8'h7F, 0, 0, 2'b00, 0, 0, 0); dres[2]  = 32'h3F800000; dfl[2]  = 3'b001;
    dv[3]  = mkv(28'h400000C, 8'h7F, 0, 0, 2'b00, 0, 0, 0); dres[3]  = 32'h3F800002; dfl[3]  = 3'b001;
    dv[4]  = mkv(28'h8000000, 8'hFE, 0, 0, 2'b00, 0, 0, 0); dres[4]  = 32'h7F800000; dfl[4]  = 3'b101;
    dv[5]  = mkv(28'h8000000, 8'hFE, 0, 0, 2'b11, 0, 0, 0); dres[5]  = 32'h7F7FFFFF; dfl[5]  = 3'b101;
    dv[6]  = mkv(28'h8000000, 8'hFE, 1, 0, 2'b10, 0, 0, 0); dres[6]  = 32'hFF7FFFFF; dfl[6]  = 3'b101;
    dv[7]  = mkv(28'h8000000, 8'hFE, 0, 0, 2'b01, 0, 0, 0); dres[7]  = 32'h7F7FFFFF; dfl[7]  = 3'b101;
    dv[8]  = mkv(28'h0000000, 8'h80, 0, 1, 2'b01, 0, 0, 0); dres[8]  = 32'h80000000; dfl[8]  = 3'b000;
    dv[9]  = mkv(28'h0000000, 8'h80, 0, 1, 2'b00, 0, 0, 0); dres[9]  = 32'h00000000; dfl[9]  = 3'b000;
    dv[10] = mkv(28'h4000000, 8'h7F, 1, 0, 2'b00, 1, 0, 23'h400001); dres[10] = 32'hFFC00001; dfl[10] = 3'b000;
    dv[11] = mkv(28'h4000000, 8'h7F, 0, 0, 2'b00, 0, 1, 0); dres[11] = 32'h7F800000; dfl[11] = 3'b000;
    dv[12] = mkv(28'h4000000, 8'h00, 0, 0, 2'b00, 0, 0, 0); dres[12] = 32'h00800000; dfl[12] = 3'b000;
    dv[13] = mkv(28'h0100000, 8'h00, 0, 0, 2'b00, 0, 0, 0); dres[13] = 32'h00020000; dfl[13] = 3'b000;
    dv[14] = mkv(28'h0100001, 8'h00, 0, 0, 2'b00, 0, 0, 0); dres[14] = 32'h00020000; dfl[14] = 3'b011;
    dv[15] = mkv(28'h7FFFFFC, 8'h7F, 0, 0, 2'b00, 0, 0, 0); dres[15] = 32'h40000000; dfl[15] = 3'b001;
    dv[16] = mkv(28'h0080000, 8'h03, 0, 0, 2'b00, 0, 0, 0); dres[16] = 32'h00040000; dfl[16] = 3'b000;
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      apply(dv[i]);
      in_valid  = 1'b1;
      out_ready = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL dir%0d_in_ready: got %b want 1", i, in_ready); end
      @(negedge clk);
      in_valid = 1'b0;
      lat = 1;
      while (out_valid !== 1'b1 && lat < 10) begin
        @(negedge clk);
        lat++;
      end
      checks++;
      if (lat !== 2) begin errors++; $display("FAIL dir%0d_latency: got %0d want 2", i, lat); end
      checks++;
      if (result !== dres[i]) begin errors++; $display("FAIL dir%0d_result: got %h want %h", i, result, dres[i]); end
      checks++;
      if (flags !== (dfl[i] & FL_MASK)) begin
        errors++; $display("FAIL dir%0d_flags: got %b want %b", i, flags, dfl[i] & FL_MASK);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    vec_t        bv[4];
    logic [34:0] e;
    int          idx, got, cyc;
    for (int i = 0; i < 4; i++) bv[i] = gen_vec();
    exp_q.delete();
    idx = 0; got = 0; cyc = 0;
    while (got < 4 && cyc < 40) begin
      @(negedge clk);
      out_ready = (cyc >= 3);
      if (idx < 4) begin apply(bv[idx]); in_valid = 1'b1; end
      else in_valid = 1'b0;
      #1;
      if (cyc == 2) begin
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_in_ready: got %b want 0", in_ready); end
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_full_out_valid: got %b want 1", out_valid); end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL bp_extra_output: got %h want none", result);
        end else begin
          e = exp_q.pop_front();
          if (result !== e[31:0]) begin errors++; $display("FAIL bp_result%0d: got %h want %h", got, result, e[31:0]); end
          checks++;
          if (flags !== (e[34:32] & FL_MASK)) begin
            errors++; $display("FAIL bp_flags%0d: got %b want %b", got, flags, e[34:32] & FL_MASK);
          end
        end
        got++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_model(bv[idx]));
        idx++;
      end
      cyc++;
    end
    in_valid = 1'b0;
    checks++;
    if (got !== 4) begin errors++; $display("FAIL bp_count: got %0d want 4", got); end
  endtask

  task automatic test_random();
    vec_t        v;
    logic [34:0] e;
    int          nout;
    exp_q.delete();
    nout = 0;
    for (int c = 0; c < 420; c++) begin
      @(negedge clk);
      if (c < 400) begin
        v = gen_vec();
        apply(v);
        in_valid  = ($urandom_range(0, 9) < 7);
        out_ready = ($urandom_range(0, 9) < 7);
      end else begin
        in_valid  = 1'b0;
        out_ready = 1'b1;
      end
      #1;
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL rnd_extra_output: got %h want none", result);
        end else begin
          e = exp_q.pop_front();
          if (result !== e[31:0]) begin errors++; $display("FAIL rnd_result%0d: got %h want %h", nout, result, e[31:0]); end
          checks++;
          if (flags !== (e[34:32] & FL_MASK)) begin
            errors++; $display("FAIL rnd_flags%0d: got %b want %b", nout, flags, e[34:32] & FL_MASK);
          end
        end
        nout++;
      end
      if (in_valid && in_ready) exp_q.push_back(ref_model(v));
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL rnd_pending: got %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_reset_midstream();
    vec_t v;
    int   stale;
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      v = gen_vec();
      apply(v);
      in_valid = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_out_valid: got %b want 0", out_valid); end
    checks++;
    if (result !== 32'h0) begin errors++; $display("FAIL mid_rst_result: got %h want 00000000", result); end
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    stale = 0;
    repeat (3) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    checks++;
    if (stale !== 0) begin errors++; $display("FAIL mid_rst_stale: got %0d outputs want 0", stale); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_random();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
